data_ram_wait: RTL and testbench

- Parametrised single-port data RAM for the MEM stage, with byte enables and a configurable number of wait states.
- Models slow memory: the block latches each request and requests a pipeline stall until the access finishes.
- It then signals completion with a one-cycle ack.
- Unlike the zero-latency data RAM, read data is registered and access latency is programmable.

---
 rtl/data_ram_wait.sv | 108 ++++++++++
 tb/tb_data_ram_wait.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_wait.sv
// Single-port data RAM with byte enables and programmable wait states.
// Each request is latched, stalls the pipeline while busy, then pulses ack for one cycle.
module data_ram_wait #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH/8-1:0] sel,
   input  logic [DATA_WIDTH-1:0]   data_i,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    stallreq,
   output logic                    ack
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int OFFS   = $clog2(NBYTES);
   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_we;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic [NBYTES-1:0]     r_sel;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_data_o;
   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  w_exec;
   logic                  w_acc_we;
   logic [DEPTH_LOG2-1:0] w_acc_idx;
   logic [NBYTES-1:0]     w_acc_sel;
   logic [DATA_WIDTH-1:0] w_acc_data;
   logic                  w_unused_addr;

   // Upper address bits alias; lower bits select a byte inside the word.
   assign w_idx         = addr[DEPTH_LOG2+OFFS-1:OFFS];
   assign w_unused_addr = ^addr;

   // With zero wait states the access executes on the accepting edge, so it
   // must use the live inputs rather than the not-yet-latched copies.
   assign w_exec     = ((r_state == S_IDLE) && ce && (WAIT_CYCLES == 0)) ||
                       ((r_state == S_BUSY) && (r_cnt == '0));
   assign w_acc_we   = (r_state == S_IDLE) ? we     : r_we;
   assign w_acc_idx  = (r_state == S_IDLE) ? w_idx  : r_idx;
   assign w_acc_sel  = (r_state == S_IDLE) ? sel    : r_sel;
   assign w_acc_data = (r_state == S_IDLE) ? data_i : r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_data_o <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ce) begin
                  r_we   <= we;
                  r_idx  <= w_idx;
                  r_sel  <= sel;
                  r_data <= data_i;
                  if (WAIT_CYCLES == 0) begin
                     r_state <= S_DONE;
                  end else begin
                     r_cnt   <= CNT_INIT;
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (r_cnt == '0) r_state <= S_DONE;
               else             r_cnt   <= r_cnt - CNT_ONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         if (w_exec && !w_acc_we) r_data_o <= r_mem[w_acc_idx];
      end
   end

   // Reset aborts an in-flight access, so the array write is gated by rst.
   always_ff @(posedge clk) begin
      if (!rst && w_exec && w_acc_we) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (w_acc_sel[b]) r_mem[w_acc_idx][b*8 +: 8] <= w_acc_data[b*8 +: 8];
         end
      end
   end

   assign data_o   = r_data_o;
   assign ack      = (r_state == S_DONE);
   assign stallreq = ((r_state == S_IDLE) && ce) || (r_state == S_BUSY);

endmodule

// File: tb/tb_data_ram_wait.sv
// Bench for data_ram_wait: one instance with two wait states, one with none,
// checked every cycle against a timeline model plus hand-computed expectations.
module tb_data_ram_wait;

   localparam int WAIT_A = 2;
   localparam int WAIT_B = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce_a, we_a, stall_a, ack_a;
   logic [31:0] addr_a, din_a, dout_a;
   logic [3:0]  sel_a;
   logic        ce_b, we_b, stall_b, ack_b;
   logic [31:0] addr_b, din_b, dout_b;
   logic [3:0]  sel_b;

   always #5 clk = ~clk;

   data_ram_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(WAIT_A)) u_dut_a (
      .clk(clk), .rst(rst), .ce(ce_a), .we(we_a), .addr(addr_a), .sel(sel_a),
      .data_i(din_a), .data_o(dout_a), .stallreq(stall_a), .ack(ack_a)
   );

   data_ram_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(WAIT_B)) u_dut_b (
      .clk(clk), .rst(rst), .ce(ce_b), .we(we_b), .addr(addr_b), .sel(sel_b),
      .data_i(din_b), .data_o(dout_b), .stallreq(stall_b), .ack(ack_b)
   );

   int checks = 0;
   int passes = 0;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   task automatic expire(input string name);
      checks++;
      $display("FAIL %s: no ack within bound, expected one", name);
   endtask

   // Model: a request accepted in cycle T owns cycles T..T+1+W; ack in the last.
   int          cyc = 0;
   bit          m_valid  [2];
   bit          m_active [2];
   int          m_acc    [2];
   int          m_ackc   [2];
   logic        m_we     [2];
   logic [31:0] m_addr   [2];
   logic [31:0] m_din    [2];
   logic [3:0]  m_sel    [2];
   logic [31:0] m_dout   [2];
   logic [31:0] m_mem    [int];

   task automatic model_step(input int u);
      logic        c, w, g_ack, g_stall, in_busy, in_done, idle;
      logic [31:0] a, d, g_dout, word;
      logic [3:0]  s;
      int          key;
      int          wt;
      wt      = (u == 0) ? WAIT_A : WAIT_B;
      c       = (u == 0) ? ce_a : ce_b;
      w       = (u == 0) ? we_a : we_b;
      a       = (u == 0) ? addr_a : addr_b;
      d       = (u == 0) ? din_a : din_b;
      s       = (u == 0) ? sel_a : sel_b;
      g_ack   = (u == 0) ? ack_a : ack_b;
      g_stall = (u == 0) ? stall_a : stall_b;
      g_dout  = (u == 0) ? dout_a : dout_b;
      in_busy = m_active[u] && (cyc > m_acc[u]) && (cyc < m_ackc[u]);
      in_done = m_active[u] && (cyc == m_ackc[u]);
      idle    = !(in_busy || in_done);
      if (m_valid[u]) begin
         check32($sformatf("ack[%0d] cyc %0d", u, cyc), {31'd0, g_ack}, {31'd0, in_done});
         check32($sformatf("stallreq[%0d] cyc %0d", u, cyc), {31'd0, g_stall},
                 {31'd0, (idle && c) || in_busy});
         check32($sformatf("data_o[%0d] cyc %0d", u, cyc), g_dout, m_dout[u]);
      end
      if (rst) begin
         m_active[u] = 1'b0;
         m_dout[u]   = 32'd0;
         m_valid[u]  = 1'b1;
      end else if (in_done) begin
         m_active[u] = 1'b0;
      end else if (idle && c) begin
         m_active[u] = 1'b1;
         m_acc[u]    = cyc;
         m_ackc[u]   = cyc + 1 + wt;
         m_we[u]     = w;
         m_addr[u]   = a;
         m_din[u]    = d;
         m_sel[u]    = s;
      end
      if (!rst && m_active[u] && (cyc == m_ackc[u] - 1)) begin
         key  = u * 65536 + int'((m_addr[u] >> 2) % 1024);
         word = m_mem.exists(key) ? m_mem[key] : 32'hxxxxxxxx;
         if (m_we[u]) begin
            for (int b = 0; b < 4; b++) if (m_sel[u][b]) word[b*8 +: 8] = m_din[u][b*8 +: 8];
            m_mem[key] = word;
         end else begin
            m_dout[u] = word;
         end
      end
   endtask

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) model_step(u);
      cyc++;
   end

   task automatic drive(input int u, input logic c, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
      if (u == 0) begin
         ce_a = c; we_a = w; addr_a = a; sel_a = s; din_a = d;
      end else begin
         ce_b = c; we_b = w; addr_b = a; sel_b = s; din_b = d;
      end
   endtask

   // Issues one request; lat is the ack cycle relative to acceptance, stv the stall trace.
   task automatic req(input int u, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output int lat, output logic [31:0] rd,
                      output logic [7:0] stv);
      lat = -1;
      rd  = 32'hxxxxxxxx;
      stv = 8'd0;
      @(posedge clk); #1;
      drive(u, 1'b1, w, a, s, d);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i < 8) stv[i] = (u == 0) ? stall_a : stall_b;
         if ((u == 0) ? ack_a : ack_b) begin
            lat = i;
            rd  = (u == 0) ? dout_a : dout_b;
            break;
         end
         @(posedge clk); #1;
         drive(u, 1'b0, w, a, s, d);
      end
      if (lat < 0) expire($sformatf("req[%0d] addr %h", u, a));
   endtask

   int          lat;
   int          nacks;
   int          pos [3];
   logic [31:0] rd;
   logic [7:0]  stv;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check32("reset ack_a", {31'd0, ack_a}, 32'd0);
         check32("reset stall_a", {31'd0, stall_a}, 32'd0);
         check32("reset data_o_a", dout_a, 32'd0);
         check32("reset data_o_b", dout_b, 32'd0);
      end

      // Full word, two wait states.
      req(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, lat, rd, stv);
      check32("write latency", lat, 32'd3);
      check32("write stall trace", {28'd0, stv[3:0]}, 32'h7);
      req(0, 1'b0, 32'h100, 4'hF, 32'd0, lat, rd, stv);
      check32("read latency", lat, 32'd3);
      check32("read data", rd, 32'hDEADBEEF);

      // Byte lanes and an empty byte mask.
      req(0, 1'b1, 32'h200, 4'hF, 32'h11223344, lat, rd, stv);
      req(0, 1'b1, 32'h200, 4'b0101, 32'hAABBCCDD, lat, rd, stv);
      req(0, 1'b0, 32'h200, 4'h0, 32'd0, lat, rd, stv);
      check32("byte lane merge", rd, 32'h11BB33DD);
      req(0, 1'b1, 32'h200, 4'h0, 32'hFFFFFFFF, lat, rd, stv);
      check32("sel0 write ack latency", lat, 32'd3);
      req(0, 1'b0, 32'h200, 4'hF, 32'd0, lat, rd, stv);
      check32("sel0 word unchanged", rd, 32'h11BB33DD);

      // Zero wait states.
      req(1, 1'b1, 32'h40, 4'hF, 32'hCAFEBABE, lat, rd, stv);
      check32("w0 write latency", lat, 32'd1);
      req(1, 1'b0, 32'h40, 4'hF, 32'd0, lat, rd, stv);
      check32("w0 read latency", lat, 32'd1);
      check32("w0 stall trace", {30'd0, stv[1:0]}, 32'h1);
      check32("w0 read data", rd, 32'hCAFEBABE);

      // Inputs and ce wiggling while busy must not disturb the latched request.
      req(0, 1'b1, 32'h300, 4'hF, 32'h12345678, lat, rd, stv);
      req(0, 1'b1, 32'h304, 4'hF, 32'h00000000, lat, rd, stv);
      @(posedge clk); #1 drive(0, 1'b1, 1'b1, 32'h300, 4'hF, 32'hA5A5A5A5);
      @(posedge clk); #1 drive(0, 1'b1, 1'b1, 32'h304, 4'hF, 32'h5A5A5A5A);
      @(posedge clk); #1 drive(0, 1'b0, 1'b0, 32'h304, 4'h0, 32'd0);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack_a) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) expire("busy-change ack");
      req(0, 1'b0, 32'h304, 4'hF, 32'd0, lat, rd, stv);
      check32("busy-change other word", rd, 32'h00000000);
      req(0, 1'b0, 32'h300, 4'hF, 32'd0, lat, rd, stv);
      check32("busy-change original", rd, 32'hA5A5A5A5);

      // Reset while busy on a write: aborted, no ack, data_o cleared.
      @(posedge clk); #1 drive(0, 1'b1, 1'b1, 32'h300, 4'hF, 32'hFFFF0000);
      @(posedge clk); #1 drive(0, 1'b0, 1'b0, 32'h300, 4'h0, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      nacks = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack_a) nacks++;
      end
      check32("abort ack count", nacks, 32'd0);
      check32("abort data_o", dout_a, 32'd0);
      req(0, 1'b0, 32'h300, 4'hF, 32'd0, lat, rd, stv);
      check32("abort word unchanged", rd, 32'hA5A5A5A5);

      // Aliasing: bit DEPTH_LOG2+2 and above are ignored.
      req(0, 1'b1, 32'h0, 4'hF, 32'h01020304, lat, rd, stv);
      req(0, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, lat, rd, stv);
      req(0, 1'b0, 32'h0, 4'hF, 32'd0, lat, rd, stv);
      check32("alias read", rd, 32'hCAFEF00D);

      // Continuous ce: one ack every WAIT+2 cycles.
      nacks = 0;
      for (int k = 0; k < 3; k++) pos[k] = -100;
      @(posedge clk); #1 drive(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ack_a) begin
            if (nacks < 3) pos[nacks] = i;
            nacks++;
         end
         @(posedge clk); #1;
      end
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'd0);
      check32("b2b ack count", nacks, 32'd3);
      check32("b2b first ack", pos[0], 32'd3);
      check32("b2b spacing 1", pos[1] - pos[0], 32'd4);
      check32("b2b spacing 2", pos[2] - pos[1], 32'd4);

      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
